// File: rtl/mem_access_pkg.sv
// Shared types and constants for the RISC-V memory-access stage: widths,
// funct3 codes, FSM state encoding and the registered bundle handed to wb.
package mem_access_pkg;

    localparam int INST_W     = 32;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    localparam int RAM_TIMEOUT = 16;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    localparam logic [2:0] INST_SB = 3'b000;
    localparam logic [2:0] INST_SH = 3'b001;
    localparam logic [2:0] INST_SW = 3'b010;

    typedef enum logic {
        MEM_ST_IDLE = 1'b0,
        MEM_ST_WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [INST_W-1:0]     inst;
        logic                  mem_r_ena;
        logic [ADDR_W-1:0]     mem_r_addr;
        logic [DATA_W-1:0]     mem_r_data;
        logic                  reg_w_ena;
        logic [REG_ADDR_W-1:0] reg_w_addr;
        logic [REG_W-1:0]      reg_w_data;
        logic                  mem_w_ena;
        logic [ADDR_W-1:0]     mem_w_addr;
        logic [DATA_W-1:0]     mem_w_data;
    } bundle_t;

    // A bubble carries no enables and all-zero data words.
    function automatic bundle_t bubble();
        bundle_t b;
        b            = '0;
        b.mem_r_data = ZERO_WORD;
        b.reg_w_data = ZERO_WORD;
        b.mem_w_data = ZERO_WORD;
        return b;
    endfunction

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_access.sv
// Memory-access stage: issues word-aligned RAM reads for loads and sub-word
// stores, stalls upstream until read data returns, and registers the wb bundle.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = RAM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  valid_i,
    input  logic [INST_W-1:0]     inst_i,
    input  logic                  mem_r_ena_i,
    input  logic [ADDR_W-1:0]     mem_r_addr_i,
    input  logic                  mem_w_ena_i,
    input  logic [ADDR_W-1:0]     mem_w_addr_i,
    input  logic [DATA_W-1:0]     mem_w_data_i,
    input  logic                  reg_w_ena_i,
    input  logic [REG_ADDR_W-1:0] reg_w_addr_i,
    input  logic [REG_W-1:0]      reg_w_data_i,
    output logic                  stall_o,
    output logic                  ram_req_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    input  logic                  ram_rvalid_i,
    input  logic [DATA_W-1:0]     ram_rdata_i,
    output logic [INST_W-1:0]     inst_o,
    output logic                  mem_r_ena_o,
    output logic [ADDR_W-1:0]     mem_r_addr_o,
    output logic [DATA_W-1:0]     mem_r_data_o,
    output logic                  reg_w_ena_o,
    output logic [REG_ADDR_W-1:0] reg_w_addr_o,
    output logic [REG_W-1:0]      reg_w_data_o,
    output logic                  mem_w_ena_o,
    output logic [ADDR_W-1:0]     mem_w_addr_o,
    output logic [DATA_W-1:0]     mem_w_data_o,
    output logic                  err_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t        state_p1, state_nxt;
    logic [CNT_W-1:0]  cnt_p1, cnt_nxt;
    bundle_t           held_p1, held_nxt;
    bundle_t           out_p1, out_nxt;
    logic              err_p1, err_nxt;

    bundle_t           in_b;
    logic              need_rd;
    logic [ADDR_W-1:0] rd_addr;
    logic              req_c;
    logic              stall_c;

    // Input decode: SW rewrites a whole word, so only loads and SB/SH need the old word.
    always_comb begin
        in_b            = bubble();
        in_b.inst       = inst_i;
        in_b.mem_r_ena  = mem_r_ena_i;
        in_b.mem_r_addr = mem_r_addr_i;
        in_b.mem_r_data = ZERO_WORD;
        in_b.reg_w_ena  = reg_w_ena_i;
        in_b.reg_w_addr = reg_w_addr_i;
        in_b.reg_w_data = reg_w_data_i;
        in_b.mem_w_ena  = mem_w_ena_i;
        in_b.mem_w_addr = mem_w_addr_i;
        in_b.mem_w_data = mem_w_data_i;
    end

    assign need_rd = valid_i & (mem_r_ena_i | (mem_w_ena_i & (inst_i[14:12] != INST_SW)));
    assign rd_addr = mem_r_ena_i ? mem_r_addr_i : mem_w_addr_i;

    always_comb begin
        state_nxt = state_p1;
        cnt_nxt   = cnt_p1;
        held_nxt  = held_p1;
        out_nxt   = bubble();
        err_nxt   = 1'b0;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        case (state_p1)
            MEM_ST_IDLE: begin
                if (need_rd) begin
                    req_c               = 1'b1;
                    stall_c             = 1'b1;
                    held_nxt            = in_b;
                    held_nxt.mem_r_addr = rd_addr;
                    cnt_nxt             = '0;
                    state_nxt           = MEM_ST_WAIT;
                end else if (valid_i) begin
                    out_nxt = in_b;
                end
            end
            MEM_ST_WAIT: begin
                // Data arriving on the last allowed cycle still wins over the timeout.
                if (ram_rvalid_i) begin
                    out_nxt            = held_p1;
                    out_nxt.mem_r_data = ram_rdata_i;
                    state_nxt          = MEM_ST_IDLE;
                end else if (cnt_p1 == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = MEM_ST_IDLE;
                end else begin
                    cnt_nxt = cnt_p1 + 1'b1;
                    stall_c = 1'b1;
                end
            end
            default: begin
                state_nxt = MEM_ST_IDLE;
            end
        endcase
    end

    // Stage p1: control and wb-facing bundle, cleared asynchronously.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_p1 <= MEM_ST_IDLE;
            cnt_p1   <= '0;
            out_p1   <= bubble();
            err_p1   <= 1'b0;
        end else begin
            state_p1 <= state_nxt;
            cnt_p1   <= cnt_nxt;
            out_p1   <= out_nxt;
            err_p1   <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        held_p1 <= held_nxt;
    end

    assign stall_o    = stall_c & arst_n;
    assign ram_req_o  = req_c & arst_n;
    assign ram_addr_o = word_align(rd_addr);

    assign inst_o       = out_p1.inst;
    assign mem_r_ena_o  = out_p1.mem_r_ena;
    assign mem_r_addr_o = out_p1.mem_r_addr;
    assign mem_r_data_o = out_p1.mem_r_data;
    assign reg_w_ena_o  = out_p1.reg_w_ena;
    assign reg_w_addr_o = out_p1.reg_w_addr;
    assign reg_w_data_o = out_p1.reg_w_data;
    assign mem_w_ena_o  = out_p1.mem_w_ena;
    assign mem_w_addr_o = out_p1.mem_w_addr;
    assign mem_w_data_o = out_p1.mem_w_data;
    assign err_o        = err_p1;

endmodule
